// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller: forward selects,
// writeback encodings, controller states and the stall/flush bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } ctrl_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } ctrl_bus_t;

  localparam ctrl_bus_t CTRL_IDLE = 7'b0000000;
  // Freeze PC..EX/MEM and drain a bubble into MEM/WB while memory is busy.
  localparam ctrl_bus_t CTRL_HOLD = 7'b1111001;
  localparam ctrl_bus_t CTRL_BR   = 7'b0000110;
  localparam ctrl_bus_t CTRL_LUSE = 7'b1100010;

  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic en);
    return en && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one EX-stage source register; the M-stage
// result is younger than W, so it wins when both match.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       rf_en_m_i,
  input  logic       rf_en_w_i,
  output fwd_sel_t   fwd_sel_o
);

  always_comb begin
    fwd_sel_o = FWD_NONE;
    if (reg_match(rd_m_i, rs_i, rf_en_m_i)) begin
      fwd_sel_o = FWD_MEM;
    end else if (reg_match(rd_w_i, rs_i, rf_en_w_i)) begin
      fwd_sel_o = FWD_WB;
    end else begin
      fwd_sel_o = FWD_NONE;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage RV32I pipeline with a
// memory wait-state FSM. Optional counters: define PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_D,
  input  logic [4:0] rs2_D,
  input  logic [4:0] rs1_E,
  input  logic [4:0] rs2_E,
  input  logic [4:0] rd_E,
  input  logic [4:0] rd_M,
  input  logic [4:0] rd_W,
  input  logic [1:0] sel_wb_E,
  input  logic       rf_en_M,
  input  logic       rf_en_W,
  input  logic       br_taken_E,
  input  logic       mem_req_M,
  input  logic       mem_ready_M,
  output logic       stall_F,
  output logic       stall_D,
  output logic       stall_E,
  output logic       stall_M,
  output logic       flush_D,
  output logic       flush_E,
  output logic       flush_W,
  output logic [1:0] fwd_a_E,
  output logic [1:0] fwd_b_E,
  output logic       mem_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_luse_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(MEM_TIMEOUT);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  fwd_sel_t  fwd_a_s, fwd_b_s;
  ctrl_bus_t ctrl_s;
  logic      luse_s;
  logic      mstall_s;
  logic      br_evt_s;
  logic      luse_evt_s;

  fwd_unit u_fwd_a (
    .rs_i      (rs1_E),
    .rd_m_i    (rd_M),
    .rd_w_i    (rd_W),
    .rf_en_m_i (rf_en_M),
    .rf_en_w_i (rf_en_W),
    .fwd_sel_o (fwd_a_s)
  );

  fwd_unit u_fwd_b (
    .rs_i      (rs2_E),
    .rd_m_i    (rd_M),
    .rd_w_i    (rd_W),
    .rf_en_m_i (rf_en_M),
    .rf_en_w_i (rf_en_W),
    .fwd_sel_o (fwd_b_s)
  );

  assign luse_s   = (sel_wb_E == WB_MEM) && (rd_E != 5'd0) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));
  assign mstall_s = mem_req_M && !mem_ready_M;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    ctrl_s     = CTRL_IDLE;
    br_evt_s   = 1'b0;
    luse_evt_s = 1'b0;
    case (state_q)
      RUN: begin
        if (mstall_s) begin
          ctrl_s     = CTRL_HOLD;
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_ONE;
        end else if (br_taken_E) begin
          // The squashed D instruction makes any concurrent load-use moot.
          ctrl_s   = CTRL_BR;
          br_evt_s = 1'b1;
        end else if (luse_s) begin
          ctrl_s     = CTRL_LUSE;
          luse_evt_s = 1'b1;
        end else begin
          ctrl_s = CTRL_IDLE;
        end
      end
      MEM_WAIT: begin
        if (mem_ready_M) begin
          ctrl_s     = CTRL_IDLE;
          state_d    = RUN;
          wait_cnt_d = CNT_ZERO;
        end else begin
          ctrl_s = CTRL_HOLD;
          if (wait_cnt_q == CNT_TIMEOUT) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
          end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
        end
      end
      ERROR: begin
        ctrl_s    = CTRL_HOLD;
        timeout_d = 1'b1;
      end
      default: begin
        ctrl_s  = CTRL_IDLE;
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= CNT_ZERO;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Reset overrides the combinational controls directly so buffers see no stray hold.
  assign stall_F     = ctrl_s.stall_f & ~rst;
  assign stall_D     = ctrl_s.stall_d & ~rst;
  assign stall_E     = ctrl_s.stall_e & ~rst;
  assign stall_M     = ctrl_s.stall_m & ~rst;
  assign flush_D     = ctrl_s.flush_d & ~rst;
  assign flush_E     = ctrl_s.flush_e & ~rst;
  assign flush_W     = ctrl_s.flush_w & ~rst;
  assign fwd_a_E     = rst ? FWD_NONE : fwd_a_s;
  assign fwd_b_E     = rst ? FWD_NONE : fwd_b_s;
  assign mem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_luse_q,  perf_luse_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    perf_luse_d  = perf_luse_q;
    if (ctrl_s.stall_d) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
    if (br_evt_s) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end else begin
      perf_flush_d = perf_flush_q;
    end
    if (luse_evt_s) begin
      perf_luse_d = perf_luse_q + 32'd1;
    end else begin
      perf_luse_d = perf_luse_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
      perf_luse_q  <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_luse_q  <= perf_luse_d;
    end
  end

  assign perf_stall_cyc = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_luse_cnt  = perf_luse_q;
`else
  logic unused_evt_s;
  assign unused_evt_s = br_evt_s ^ luse_evt_s;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, hand-written
// memory-wait/timeout/reset sequences, then random stimulus against a model.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TO = 4;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_HOLD = 7'b1111001;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_LUSE = 7'b1100010;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic [1:0] sel_wb_E;
  logic       rf_en_M, rf_en_W, br_taken_E, mem_req_M, mem_ready_M;
  logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic       mem_timeout;
  logic [11:0] got;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_luse_cnt;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W), .sel_wb_E(sel_wb_E),
    .rf_en_M(rf_en_M), .rf_en_W(rf_en_W), .br_taken_E(br_taken_E),
    .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .mem_timeout(mem_timeout)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
    .perf_luse_cnt(perf_luse_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign got = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
                fwd_a_E, fwd_b_E, mem_timeout};

  typedef struct {
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic [1:0] sel_wb_E;
    logic       rf_en_M, rf_en_W, br, req, rdy;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: an access is "dead" once it has sat unresolved in the
  // wait state for TO cycles beyond the cycle it first stalled.
  bit m_err, m_wait;
  int m_start, cyc;

  function automatic logic [11:0] mk(input logic [6:0] ctl, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic tmo);
    return {ctl, fa, fb, tmo};
  endfunction

  function automatic stim_t zero_stim();
    stim_t s;
    s.rs1_D = 5'd0; s.rs2_D = 5'd0; s.rs1_E = 5'd0; s.rs2_E = 5'd0;
    s.rd_E = 5'd0; s.rd_M = 5'd0; s.rd_W = 5'd0; s.sel_wb_E = 2'b00;
    s.rf_en_M = 1'b0; s.rf_en_W = 1'b0; s.br = 1'b0; s.req = 1'b0; s.rdy = 1'b0;
    return s;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rf_en_M && rd_M != 5'd0 && rd_M == rs) return 2'b01;
    if (rf_en_W && rd_W != 5'd0 && rd_W == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [11:0] model_exp();
    logic       luse, hold;
    logic [6:0] ctl;
    if (rst) return 12'h000;
    luse = (sel_wb_E == 2'b01) && rd_E != 5'd0 && (rd_E == rs1_D || rd_E == rs2_D);
    hold = m_err || (m_wait && !mem_ready_M) || (!m_wait && mem_req_M && !mem_ready_M);
    if (hold)            ctl = C_HOLD;
    else if (m_wait)     ctl = C_NONE;
    else if (br_taken_E) ctl = C_BR;
    else if (luse)       ctl = C_LUSE;
    else                 ctl = C_NONE;
    return {ctl, ref_fwd(rs1_E), ref_fwd(rs2_E), m_err};
  endfunction

  task automatic model_tick();
    if (rst) begin
      m_err = 1'b0; m_wait = 1'b0;
    end else if (m_err) begin
      m_err = 1'b1;
    end else if (m_wait) begin
      if (mem_ready_M) m_wait = 1'b0;
      else if (cyc - m_start == TO) m_err = 1'b1;
    end else if (mem_req_M && !mem_ready_M) begin
      m_wait = 1'b1; m_start = cyc;
    end
  endtask

  task automatic apply(input stim_t s);
    rs1_D = s.rs1_D; rs2_D = s.rs2_D; rs1_E = s.rs1_E; rs2_E = s.rs2_E;
    rd_E = s.rd_E; rd_M = s.rd_M; rd_W = s.rd_W; sel_wb_E = s.sel_wb_E;
    rf_en_M = s.rf_en_M; rf_en_W = s.rf_en_W; br_taken_E = s.br;
    mem_req_M = s.req; mem_ready_M = s.rdy;
  endtask

  task automatic check(input string name, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %03h expected %03h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Inputs are applied at negedge; outputs sampled 1 time unit later.
  task automatic step(input string name, input logic [11:0] exp);
    #1;
    check(name, exp);
    @(posedge clk);
    model_tick();
    cyc++;
    @(negedge clk);
  endtask

  task automatic add_vec(input stim_t s, input logic [11:0] e, input string n);
    vq.push_back('{s: s, exp: e, name: n});
  endtask

  initial begin
    stim_t s;
    m_err = 1'b0; m_wait = 1'b0; m_start = 0; cyc = 0;

    // Directed single-cycle vectors, all applied from RUN with no memory access.
    s = zero_stim(); s.rs1_E = 5'd5; s.rd_M = 5'd5; s.rf_en_M = 1'b1;
    s.rd_W = 5'd5; s.rf_en_W = 1'b1;
    add_vec(s, mk(C_NONE, 2'b01, 2'b00, 1'b0), "fwd_m_priority");
    s.rf_en_M = 1'b0;
    add_vec(s, mk(C_NONE, 2'b10, 2'b00, 1'b0), "fwd_wb");
    s.rd_W = 5'd0;
    add_vec(s, mk(C_NONE, 2'b00, 2'b00, 1'b0), "fwd_none_x0");
    s = zero_stim(); s.rs2_E = 5'd7; s.rd_M = 5'd7; s.rf_en_M = 1'b1;
    s.rd_W = 5'd9; s.rf_en_W = 1'b1; s.rs1_E = 5'd9;
    add_vec(s, mk(C_NONE, 2'b10, 2'b01, 1'b0), "fwd_b_mem_a_wb");
    s = zero_stim(); s.rf_en_M = 1'b1; s.rf_en_W = 1'b1;
    add_vec(s, mk(C_NONE, 2'b00, 2'b00, 1'b0), "fwd_x0_never");
    s = zero_stim(); s.sel_wb_E = 2'b01; s.rd_E = 5'd3; s.rs2_D = 5'd3;
    add_vec(s, mk(C_LUSE, 2'b00, 2'b00, 1'b0), "luse_rs2");
    s = zero_stim(); s.rd_M = 5'd3; s.rf_en_M = 1'b1; s.rs2_E = 5'd3;
    add_vec(s, mk(C_NONE, 2'b00, 2'b01, 1'b0), "luse_after");
    s = zero_stim(); s.sel_wb_E = 2'b10; s.rd_E = 5'd3; s.rs1_D = 5'd3;
    add_vec(s, mk(C_NONE, 2'b00, 2'b00, 1'b0), "luse_not_load");
    s = zero_stim(); s.sel_wb_E = 2'b01;
    add_vec(s, mk(C_NONE, 2'b00, 2'b00, 1'b0), "luse_rd_x0");
    s = zero_stim(); s.br = 1'b1; s.sel_wb_E = 2'b01; s.rd_E = 5'd4; s.rs1_D = 5'd4;
    add_vec(s, mk(C_BR, 2'b00, 2'b00, 1'b0), "br_over_luse");
    s = zero_stim(); s.br = 1'b1;
    add_vec(s, mk(C_BR, 2'b00, 2'b00, 1'b0), "br_only");

    // Reset state, with a forwarding match present that must be masked.
    s = zero_stim(); s.rs1_E = 5'd5; s.rd_M = 5'd5; s.rf_en_M = 1'b1;
    s.req = 1'b1; s.br = 1'b1;
    apply(s);
    rst = 1'b1;
    #1 check("reset_outputs", 12'h000);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      apply(vq[i].s);
      step(vq[i].name, vq[i].exp);
    end

    // Memory wait: three not-ready cycles then ready.
    s = zero_stim(); s.req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(s);
      step("mem_wait_hold", mk(C_HOLD, 2'b00, 2'b00, 1'b0));
    end
    s.rdy = 1'b1; apply(s);
    step("mem_wait_ready", mk(C_NONE, 2'b00, 2'b00, 1'b0));
    s = zero_stim(); s.sel_wb_E = 2'b01; s.rd_E = 5'd6; s.rs1_D = 5'd6; apply(s);
    step("mem_wait_back_run", mk(C_LUSE, 2'b00, 2'b00, 1'b0));

    // Branch arriving under a memory stall waits for the release.
    s = zero_stim(); s.req = 1'b1; s.br = 1'b1;
    for (int k = 0; k < 2; k++) begin
      apply(s);
      step("br_held_no_flush", mk(C_HOLD, 2'b00, 2'b00, 1'b0));
    end
    s.rdy = 1'b1; apply(s);
    step("br_held_release", mk(C_NONE, 2'b00, 2'b00, 1'b0));
    s = zero_stim(); s.br = 1'b1; apply(s);
    step("br_held_flush", mk(C_BR, 2'b00, 2'b00, 1'b0));
    s = zero_stim(); apply(s);
    step("br_held_after", mk(C_NONE, 2'b00, 2'b00, 1'b0));

    // Timeout: flag rises after the fifth stalled cycle and is sticky.
    s = zero_stim(); s.req = 1'b1;
    for (int k = 0; k < TO + 1; k++) begin
      apply(s);
      step("tmo_pending", mk(C_HOLD, 2'b00, 2'b00, 1'b0));
    end
    s.rdy = 1'b1; s.rs1_E = 5'd5; s.rd_M = 5'd5; s.rf_en_M = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(s);
      step("tmo_sticky", mk(C_HOLD, 2'b01, 2'b00, 1'b1));
    end
    #2 rst = 1'b1;
    #1 check("tmo_async_clear", 12'h000);
    model_tick();
    @(negedge clk);
    rst = 1'b0;
    s = zero_stim(); s.rs1_E = 5'd5; s.rd_M = 5'd5; s.rf_en_M = 1'b1; apply(s);
    step("tmo_after_reset", mk(C_NONE, 2'b01, 2'b00, 1'b0));

    // Random phase against the reference model.
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct = (((i / 250) % 3) == 2) ? 3 : 50;
      rs1_D = 5'($urandom_range(0, 3)); rs2_D = 5'($urandom_range(0, 3));
      rs1_E = 5'($urandom_range(0, 3)); rs2_E = 5'($urandom_range(0, 3));
      rd_E = 5'($urandom_range(0, 3)); rd_M = 5'($urandom_range(0, 3));
      rd_W = 5'($urandom_range(0, 3)); sel_wb_E = 2'($urandom_range(0, 3));
      rf_en_M = ($urandom_range(0, 1) == 1); rf_en_W = ($urandom_range(0, 1) == 1);
      br_taken_E = ($urandom_range(0, 5) == 0);
      mem_req_M = ($urandom_range(0, 2) == 0);
      mem_ready_M = ($urandom_range(1, 100) <= rdy_pct);
      rst = ((i % 400) == 399);
      step("random", model_exp());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
